seg_scan_decoder: RTL and testbench
===================================

# seg_scan_decoder

Receiving end of the multiplexed 4-digit 7-segment bus produced by the display driver.
- Samples the active-low digit-select and segment lines and filters out the transient mismatch between select and segment data.
- Decodes each stable segment pattern back to a BCD nibble plus decimal point, and reassembles complete 4-digit frames.
- Sits on the board-test/loopback path and in self-check benches, observing the same pins the display sees.

## Interface
- STABLE_CNT, 4: consecutive identical samples required before a digit is captured (≥2).
- TIMEOUT_CNT, 200_000: cycles without a capture before the link is declared lost.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- sel_in  in  4  digit select, active-low one-hot; 4'b1110 = digit 0 … 4'b0111 = digit 3.
- seg_in  in  8  {dp,g,f,e,d,c,b,a}, active-low.
- digits  out  16  decoded nibbles; digit n in [4n+3:4n].
- dots  out  4  decimal point per digit, active-high (1 = lit).
- frame_valid  out  1  one-cycle pulse: all four digits refreshed since last pulse.
- pattern_err  out  1  one-cycle pulse: stable pattern not in decode table.
- link_lost  out  1  level, high in LOST state.

## Operation
- Input stage: {sel_in,seg_in} pass through the input register stage (see Configuration), then the sample register `prev`.
- Stability counter:
  - Cleared when the current sample ≠ prev.
  - Increments when equal, saturating at STABLE_CNT-1.
  - Reaching STABLE_CNT-1 with `armed`=1 issues one capture and clears `armed`.
  - Any sample change re-arms, giving one capture per stable interval.
- Select with other than exactly one zero bit: no capture, counter still runs, no error.
- Decode of seg[6:0]:
  - 0–9 use the standard table (0=100_0000 … 9=001_0000).
  - 111_1111 (blank) → 4'hB, no error.
  - Any other pattern → 4'hF, pattern_err pulses in the capture cycle+1.
- Capture writes digits[idx], dots[idx]=~seg[7], and sets seen[idx].
- Frame assembly:
  - When seen becomes 4'b1111, frame_valid pulses on the next cycle and seen clears.
  - A repeat capture of an already-seen digit only overwrites that digit's value.
- Link FSM:
  - LOST (reset) → SYNC on the first capture.
  - SYNC → LOCKED on the first frame_valid.
  - SYNC/LOCKED → LOST when the idle counter reaches TIMEOUT_CNT-1.
- Idle counter:
  - Cleared by each capture, otherwise increments and saturates.
  - Entering LOST clears seen. digits and dots hold their last values.
- frame_valid is issued in SYNC and LOCKED. The cycle that completes the first frame moves the FSM to LOCKED.
- Simultaneous capture and timeout in the same cycle: the capture wins, the idle counter clears and the state is kept.

## Timing
- Reset values:
  - digits=16'hBBBB, dots=4'b0000.
  - frame_valid=0, pattern_err=0, link_lost=1.
  - seen=0, armed=1, both counters 0.
- Latency with the synchronizer:
  - Inputs constant from edge k → sample visible at k+2.
  - Capture (digits/dots updated) at edge k+2+STABLE_CNT.
  - pattern_err and frame_valid one edge later.
- Input pulses shorter than STABLE_CNT cycles are never captured.
- Reset asserted mid-frame: all state returns to reset values immediately. The first frame after release needs all four digits again.

## Configuration
- SEG_DEC_SYNC_EN defined: two-flop synchronizer on all 12 inputs. Capture latency is 2+STABLE_CNT.
- Not defined: a single register stage, for on-chip loopback from a same-clock driver. All latencies drop by one cycle and behaviour is otherwise identical.

## Structure
- Package seg_dec_pkg holds:
  - the ten segment pattern constants, shared with the display driver;
  - BLANK_PAT;
  - nibble codes NIB_BLANK=4'hB and NIB_ERR=4'hF;
  - the link state enum {LOST,SYNC,LOCKED}.
- Sub-module seg_pattern_decode: combinational 7-bit pattern → {nibble, err}, reused by the bench scoreboard.

## Test plan
- Driver-style stimulus, STABLE_CNT=4, digits 1,2,3,4 each held 50 cycles, dp lit on digits 0 and 2 → digits=16'h4321, dots=4'b0101, one frame_valid per scan, link_lost falls on the first capture.
- seg changes 2 cycles after the sel change (driver skew) → no capture of the mismatched pair; values are the same as with zero skew.
- Pattern 7'b011_1111 held on digit 1 → digits[7:4]=4'hF, exactly one pattern_err pulse per stable interval.
- Glitch: pattern held 3 cycles with STABLE_CNT=4 → no capture. Invalid sel 4'b1100 held 100 cycles → no capture, no error.
- Inputs frozen for TIMEOUT_CNT cycles (set to 1000 in the bench) → link_lost rises at cycle 1000, seen cleared, digits held. Resumed scanning → SYNC, then LOCKED after the next full frame.
- rst pulsed after digits 0–1 are captured → digits=16'hBBBB. The next frame_valid occurs only after all four digits are captured again.

Source files
------------

// File: rtl/seg_scan_decoder_pkg.sv
// Shared constants for the 7-segment scan decoder: active-low segment patterns,
// nibble codes, link state encoding and the digit-select decode helper.
package seg_dec_pkg;

  // Active-low {g,f,e,d,c,b,a}; must stay identical to the display driver tables.
  localparam logic [6:0] SEG_PAT_0 = 7'b100_0000;
  localparam logic [6:0] SEG_PAT_1 = 7'b111_1001;
  localparam logic [6:0] SEG_PAT_2 = 7'b010_0100;
  localparam logic [6:0] SEG_PAT_3 = 7'b011_0000;
  localparam logic [6:0] SEG_PAT_4 = 7'b001_1001;
  localparam logic [6:0] SEG_PAT_5 = 7'b001_0010;
  localparam logic [6:0] SEG_PAT_6 = 7'b000_0010;
  localparam logic [6:0] SEG_PAT_7 = 7'b111_1000;
  localparam logic [6:0] SEG_PAT_8 = 7'b000_0000;
  localparam logic [6:0] SEG_PAT_9 = 7'b001_0000;
  localparam logic [6:0] BLANK_PAT = 7'b111_1111;

  localparam logic [3:0] NIB_BLANK = 4'hB;
  localparam logic [3:0] NIB_ERR   = 4'hF;

  typedef enum logic [1:0] {
    LOST   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } link_state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } sel_info_t;

  function automatic sel_info_t sel_decode(input logic [3:0] sel);
    sel_info_t r;
    r.valid = 1'b1;
    r.idx   = 2'd0;
    case (sel)
      4'b1110: r.idx = 2'd0;
      4'b1101: r.idx = 2'd1;
      4'b1011: r.idx = 2'd2;
      4'b0111: r.idx = 2'd3;
      default: r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Pin bundle between a multiplexed display driver (master) and the scan decoder (slave).
interface seg_scan_decoder_if;
  logic [3:0]  sel_in;
  logic [7:0]  seg_in;
  logic [15:0] digits;
  logic [3:0]  dots;
  logic        frame_valid;
  logic        pattern_err;
  logic        link_lost;

  modport master (
    output sel_in, seg_in,
    input  digits, dots, frame_valid, pattern_err, link_lost
  );

  modport slave (
    input  sel_in, seg_in,
    output digits, dots, frame_valid, pattern_err, link_lost
  );
endinterface

// File: rtl/seg_pattern_decode.sv
// Combinational 7-segment pattern to BCD nibble decoder; blank decodes to NIB_BLANK,
// anything outside the table to NIB_ERR with err set.
module seg_pattern_decode
  import seg_dec_pkg::*;
(
  input  logic [6:0] pat,
  output logic [3:0] nib,
  output logic       err
);

  // Table lookup; the default arm covers every unlisted pattern.
  always_comb begin
    nib = NIB_ERR;
    err = 1'b1;
    case (pat)
      SEG_PAT_0: begin nib = 4'd0;      err = 1'b0; end
      SEG_PAT_1: begin nib = 4'd1;      err = 1'b0; end
      SEG_PAT_2: begin nib = 4'd2;      err = 1'b0; end
      SEG_PAT_3: begin nib = 4'd3;      err = 1'b0; end
      SEG_PAT_4: begin nib = 4'd4;      err = 1'b0; end
      SEG_PAT_5: begin nib = 4'd5;      err = 1'b0; end
      SEG_PAT_6: begin nib = 4'd6;      err = 1'b0; end
      SEG_PAT_7: begin nib = 4'd7;      err = 1'b0; end
      SEG_PAT_8: begin nib = 4'd8;      err = 1'b0; end
      SEG_PAT_9: begin nib = 4'd9;      err = 1'b0; end
      BLANK_PAT: begin nib = NIB_BLANK; err = 1'b0; end
      default:   begin nib = NIB_ERR;   err = 1'b1; end
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Receiver for a multiplexed 4-digit 7-segment bus: filters select/segment skew,
// decodes digits and assembles frames. Define SEG_DEC_SYNC_EN for a two-flop input synchronizer.
module seg_scan_decoder
  import seg_dec_pkg::*;
#(
  parameter int STABLE_CNT  = 4,
  parameter int TIMEOUT_CNT = 200_000
) (
  input  logic             clk,
  input  logic             rst,
  seg_scan_decoder_if.slave bus
);

  localparam int SW = $clog2(STABLE_CNT);
  localparam int TW = $clog2(TIMEOUT_CNT);
  localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_CNT - 1);
  localparam logic [TW-1:0] IDLE_MAX   = TW'(TIMEOUT_CNT - 1);

  logic [11:0] samp_q, prev_q;
`ifdef SEG_DEC_SYNC_EN
  logic [11:0] sync1_q;

  // Two-flop synchronizer for pins driven from an unrelated clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 12'hFFF;
      samp_q  <= 12'hFFF;
    end else begin
      sync1_q <= {bus.sel_in, bus.seg_in};
      samp_q  <= sync1_q;
    end
  end
`else
  // Single register stage for a same-clock loopback driver.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) samp_q <= 12'hFFF;
    else     samp_q <= {bus.sel_in, bus.seg_in};
  end
`endif

  logic [SW-1:0] stab_d, stab_q;
  logic [TW-1:0] idle_d, idle_q;
  logic          armed_d, armed_q;
  logic [15:0]   digits_d, digits_q;
  logic [3:0]    dots_d, dots_q, seen_d, seen_q;
  logic          frame_valid_d, frame_valid_q, pattern_err_d, pattern_err_q;
  logic          link_lost_d, link_lost_q;
  link_state_t   state_d, state_q;

  logic          same_s, capture_s, timeout_s, dec_err;
  logic [3:0]    dec_nib;
  sel_info_t     sel_info;

  assign same_s   = (samp_q == prev_q);
  assign sel_info = sel_decode(prev_q[11:8]);

  seg_pattern_decode u_decode (
    .pat (prev_q[6:0]),
    .nib (dec_nib),
    .err (dec_err)
  );

  // Stability filter, capture decision and data/frame bookkeeping.
  always_comb begin
    stab_d   = 0;
    armed_d  = armed_q;
    if (!same_s) begin
      stab_d  = 0;
      armed_d = 1'b1;
    end else begin
      stab_d = (stab_q == STABLE_MAX) ? stab_q : stab_q + 1'b1;
      if (stab_d == STABLE_MAX) armed_d = 1'b0;
      else                      armed_d = armed_q;
    end
    capture_s = same_s && armed_q && (stab_d == STABLE_MAX) && sel_info.valid;

    digits_d = digits_q;
    dots_d   = dots_q;
    if (capture_s) begin
      digits_d[{sel_info.idx, 2'b00} +: 4] = dec_nib;
      dots_d[sel_info.idx]                 = ~prev_q[7];
    end else begin
      digits_d = digits_q;
    end
    pattern_err_d = capture_s && dec_err;
    frame_valid_d = (seen_q == 4'hF) && (state_q != LOST);

    if (capture_s)                idle_d = 0;
    else if (idle_q == IDLE_MAX)  idle_d = idle_q;
    else                          idle_d = idle_q + 1'b1;
    // Capture in the same cycle as the timeout keeps the link up.
    timeout_s = (idle_q == IDLE_MAX) && !capture_s;
  end

  // Link state machine and seen-mask maintenance.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOST: begin
        if (capture_s) state_d = SYNC;
        else           state_d = LOST;
      end
      SYNC: begin
        if (timeout_s)          state_d = LOST;
        else if (frame_valid_d) state_d = LOCKED;
        else                    state_d = SYNC;
      end
      LOCKED: begin
        if (timeout_s) state_d = LOST;
        else           state_d = LOCKED;
      end
      default: state_d = LOST;
    endcase

    seen_d = (seen_q == 4'hF) ? 4'h0 : seen_q;
    if (state_d == LOST && state_q != LOST) begin
      seen_d = 4'h0;
    end else if (capture_s) begin
      seen_d[sel_info.idx] = 1'b1;
    end else begin
      seen_d = (seen_q == 4'hF) ? 4'h0 : seen_q;
    end
    link_lost_d = (state_d == LOST);
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q        <= 12'hFFF;
      stab_q        <= '0;
      idle_q        <= '0;
      armed_q       <= 1'b1;
      digits_q      <= 16'hBBBB;
      dots_q        <= 4'b0000;
      seen_q        <= 4'b0000;
      frame_valid_q <= 1'b0;
      pattern_err_q <= 1'b0;
      link_lost_q   <= 1'b1;
      state_q       <= LOST;
    end else begin
      prev_q        <= samp_q;
      stab_q        <= stab_d;
      idle_q        <= idle_d;
      armed_q       <= armed_d;
      digits_q      <= digits_d;
      dots_q        <= dots_d;
      seen_q        <= seen_d;
      frame_valid_q <= frame_valid_d;
      pattern_err_q <= pattern_err_d;
      link_lost_q   <= link_lost_d;
      state_q       <= state_d;
    end
  end

  assign bus.digits      = digits_q;
  assign bus.dots        = dots_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.pattern_err = pattern_err_q;
  assign bus.link_lost   = link_lost_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed self-checking bench for seg_scan_decoder (STABLE_CNT=4, TIMEOUT_CNT=1000).
module tb_seg_scan_decoder;

  localparam logic [6:0] P1 = 7'b111_1001, P2 = 7'b010_0100, P3 = 7'b011_0000;
  localparam logic [6:0] P4 = 7'b001_1001, P5 = 7'b001_0010, P6 = 7'b000_0010;
  localparam logic [6:0] P7 = 7'b111_1000, P8 = 7'b000_0000, P9 = 7'b001_0000;
  localparam logic [6:0] PBLANK = 7'b111_1111, PDASH = 7'b011_1111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   fv_total = 0;
  int   pe_total = 0;

  seg_scan_decoder_if bus ();

  seg_scan_decoder #(.STABLE_CNT(4), .TIMEOUT_CNT(1000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.frame_valid === 1'b1) fv_total++;
    if (bus.pattern_err === 1'b1) pe_total++;
  end

  task automatic show(input int d, input logic [6:0] pat, input logic dp,
                      input int hold, input int skew);
    logic [3:0] s;
    s = 4'b1111;
    s[d] = 1'b0;
    bus.sel_in = s;
    repeat (skew) @(negedge clk);
    bus.seg_in = {~dp, pat};
    repeat (hold - skew) @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.sel_in = 4'b1111;
    bus.seg_in = 8'hFF;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input logic [6:0] p0, p1, p2, p3, input logic [3:0] dpm, input int skew);
    show(0, p0, dpm[0], 50, skew);
    show(1, p1, dpm[1], 50, skew);
    show(2, p2, dpm[2], 50, skew);
    show(3, p3, dpm[3], 50, skew);
  endtask

  task automatic test_reset;
    bus.sel_in = 4'b1111;
    bus.seg_in = 8'hFF;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.digits !== 16'hBBBB) begin errors++; $display("FAIL reset_digits got %h exp %h", bus.digits, 16'hBBBB); end
    checks++; if (bus.dots !== 4'b0000) begin errors++; $display("FAIL reset_dots got %b exp %b", bus.dots, 4'b0000); end
    checks++; if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fv got %b exp 0", bus.frame_valid); end
    checks++; if (bus.pattern_err !== 1'b0) begin errors++; $display("FAIL reset_pe got %b exp 0", bus.pattern_err); end
    checks++; if (bus.link_lost !== 1'b1) begin errors++; $display("FAIL reset_link_lost got %b exp 1", bus.link_lost); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_scan;
    int fv0, pe0;
    fv0 = fv_total; pe0 = pe_total;
    show(0, P1, 1'b1, 50, 0);
    checks++; if (bus.link_lost !== 1'b0) begin errors++; $display("FAIL scan_link_lost got %b exp 0", bus.link_lost); end
    show(1, P2, 1'b0, 50, 0);
    show(2, P3, 1'b1, 50, 0);
    show(3, P4, 1'b0, 50, 0);
    scan(P1, P2, P3, P4, 4'b0101, 0);
    checks++; if (bus.digits !== 16'h4321) begin errors++; $display("FAIL scan_digits got %h exp %h", bus.digits, 16'h4321); end
    checks++; if (bus.dots !== 4'b0101) begin errors++; $display("FAIL scan_dots got %b exp %b", bus.dots, 4'b0101); end
    checks++; if (fv_total - fv0 !== 2) begin errors++; $display("FAIL scan_frames got %0d exp 2", fv_total - fv0); end
    checks++; if (pe_total - pe0 !== 0) begin errors++; $display("FAIL scan_perr got %0d exp 0", pe_total - pe0); end
  endtask

  task automatic test_skew;
    int fv0, pe0;
    fv0 = fv_total; pe0 = pe_total;
    scan(P5, P6, P7, P8, 4'b1010, 2);
    scan(P5, P6, P7, P8, 4'b1010, 2);
    checks++; if (bus.digits !== 16'h8765) begin errors++; $display("FAIL skew_digits got %h exp %h", bus.digits, 16'h8765); end
    checks++; if (bus.dots !== 4'b1010) begin errors++; $display("FAIL skew_dots got %b exp %b", bus.dots, 4'b1010); end
    checks++; if (fv_total - fv0 !== 2) begin errors++; $display("FAIL skew_frames got %0d exp 2", fv_total - fv0); end
    checks++; if (pe_total - pe0 !== 0) begin errors++; $display("FAIL skew_perr got %0d exp 0", pe_total - pe0); end
  endtask

  task automatic test_bad_pattern;
    int pe0;
    pe0 = pe_total;
    show(1, PDASH, 1'b0, 50, 0);
    checks++; if (bus.digits[7:4] !== 4'hF) begin errors++; $display("FAIL bad_nibble got %h exp F", bus.digits[7:4]); end
    checks++; if (pe_total - pe0 !== 1) begin errors++; $display("FAIL bad_perr_once got %0d exp 1", pe_total - pe0); end
    show(2, PBLANK, 1'b0, 50, 0);
    checks++; if (bus.digits[11:8] !== 4'hB) begin errors++; $display("FAIL blank_nibble got %h exp B", bus.digits[11:8]); end
    checks++; if (pe_total - pe0 !== 1) begin errors++; $display("FAIL blank_perr got %0d exp 1", pe_total - pe0); end
    show(1, PDASH, 1'b0, 50, 0);
    checks++; if (pe_total - pe0 !== 2) begin errors++; $display("FAIL bad_perr_twice got %0d exp 2", pe_total - pe0); end
  endtask

  task automatic test_glitch;
    int fv0, pe0;
    show(0, P3, 1'b0, 50, 0);
    idle(20);
    fv0 = fv_total; pe0 = pe_total;
    show(0, P9, 1'b0, 3, 0);
    idle(20);
    checks++; if (bus.digits[3:0] !== 4'h3) begin errors++; $display("FAIL glitch_3cyc got %h exp 3", bus.digits[3:0]); end
    show(0, P7, 1'b0, 4, 0);
    idle(20);
    checks++; if (bus.digits[3:0] !== 4'h7) begin errors++; $display("FAIL hold_4cyc got %h exp 7", bus.digits[3:0]); end
    bus.sel_in = 4'b1100;
    bus.seg_in = {1'b1, P2};
    repeat (100) @(negedge clk);
    checks++; if (bus.digits !== 16'h8BF7) begin errors++; $display("FAIL badsel_digits got %h exp %h", bus.digits, 16'h8BF7); end
    checks++; if (bus.dots !== 4'b1000) begin errors++; $display("FAIL badsel_dots got %b exp %b", bus.dots, 4'b1000); end
    checks++; if (pe_total - pe0 !== 0) begin errors++; $display("FAIL badsel_perr got %0d exp 0", pe_total - pe0); end
    checks++; if (fv_total - fv0 !== 0) begin errors++; $display("FAIL badsel_frames got %0d exp 0", fv_total - fv0); end
  endtask

  task automatic test_timeout;
    int fv0;
    show(0, P1, 1'b0, 50, 0);
    bus.sel_in = 4'b1101;
    bus.seg_in = {1'b1, P2};
    repeat (950) @(negedge clk);
    checks++; if (bus.link_lost !== 1'b0) begin errors++; $display("FAIL timeout_early got %b exp 0", bus.link_lost); end
    repeat (100) @(negedge clk);
    checks++; if (bus.link_lost !== 1'b1) begin errors++; $display("FAIL timeout_lost got %b exp 1", bus.link_lost); end
    checks++; if (bus.digits !== 16'h8B21) begin errors++; $display("FAIL timeout_digits got %h exp %h", bus.digits, 16'h8B21); end
    fv0 = fv_total;
    show(2, P3, 1'b0, 50, 0);
    show(3, P4, 1'b0, 50, 0);
    checks++; if (bus.link_lost !== 1'b0) begin errors++; $display("FAIL resume_link got %b exp 0", bus.link_lost); end
    checks++; if (fv_total - fv0 !== 0) begin errors++; $display("FAIL resume_seen_cleared got %0d exp 0", fv_total - fv0); end
    show(0, P1, 1'b0, 50, 0);
    show(1, P2, 1'b0, 50, 0);
    checks++; if (fv_total - fv0 !== 1) begin errors++; $display("FAIL resume_frame got %0d exp 1", fv_total - fv0); end
  endtask

  task automatic test_reset_mid;
    int fv0;
    idle(10);
    show(0, P9, 1'b1, 50, 0);
    show(1, P8, 1'b0, 50, 0);
    idle(5);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.digits !== 16'hBBBB) begin errors++; $display("FAIL midrst_digits got %h exp %h", bus.digits, 16'hBBBB); end
    checks++; if (bus.dots !== 4'b0000) begin errors++; $display("FAIL midrst_dots got %b exp 0000", bus.dots); end
    checks++; if (bus.link_lost !== 1'b1) begin errors++; $display("FAIL midrst_link got %b exp 1", bus.link_lost); end
    rst = 1'b0;
    idle(5);
    fv0 = fv_total;
    show(2, P7, 1'b0, 50, 0);
    show(3, P6, 1'b0, 50, 0);
    checks++; if (fv_total - fv0 !== 0) begin errors++; $display("FAIL midrst_partial got %0d exp 0", fv_total - fv0); end
    show(0, P5, 1'b0, 50, 0);
    show(1, P4, 1'b0, 50, 0);
    checks++; if (fv_total - fv0 !== 1) begin errors++; $display("FAIL midrst_frame got %0d exp 1", fv_total - fv0); end
    checks++; if (bus.digits !== 16'h6745) begin errors++; $display("FAIL midrst_digits_after got %h exp %h", bus.digits, 16'h6745); end
  endtask

  initial begin
    bus.sel_in = 4'b1111;
    bus.seg_in = 8'hFF;
    test_reset();
    test_scan();
    test_skew();
    test_bad_pattern();
    test_glitch();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
